// File: rtl/interrupt_timing_ctrl.sv
// interrupt_timing_ctrl: T-state sequencer, instruction register and interrupt/reset vector control
module interrupt_timing_ctrl (
  input  logic       phi2,
  input  logic       rst,
  input  logic       RDY,
  input  logic       NMI_n,
  input  logic       IRQ_n,
  input  logic       I_flag,
  input  logic       t_end,
  input  logic [7:0] dataIn,
  output logic [7:0] IR,
  output logic [6:0] tstate,
  output logic       SYNC,
  output logic [1:0] int_type,
  output logic       B,
  output logic       I_set,
  output logic       rw_suppress,
  output logic       O_ADL0,
  output logic       O_ADL1,
  output logic       O_ADL2,
  output logic       t_ovf
);
  logic       nmi_q, nmi_pend, take_int, res_pend;
  logic       seq, nmi_edge, nmi_clr, hijack, vec_cyc;
  logic [1:0] win;
  // Decode of registered state; every output depends only on registers
  always_comb begin
    seq         = IR == 8'h00;
    vec_cyc     = seq & |tstate[6:5];
    nmi_edge    = nmi_q & ~NMI_n;
    nmi_clr     = RDY & seq & tstate[5] & (int_type == 2'b10);
    hijack      = seq & |tstate[4:1] & nmi_pend & (int_type != 2'b11);
    win         = res_pend ? 2'b11 : nmi_pend ? 2'b10 : 2'b01;
    SYNC        = tstate[0];
    I_set       = seq & tstate[5];
    O_ADL0      = ~(seq & tstate[5]);
    O_ADL1      = ~(vec_cyc & (int_type == 2'b11));
    O_ADL2      = ~(vec_cyc & (int_type == 2'b10));
    rw_suppress = seq & (int_type == 2'b11) & |tstate[4:2];
  end
  // NMI edge detector runs regardless of RDY so a pulse during a freeze is not lost; set wins over clear
  always_ff @(posedge phi2) begin
    if (rst) begin
      nmi_q    <= 1'b1;
      nmi_pend <= 1'b0;
    end else begin
      nmi_q    <= NMI_n;
      nmi_pend <= nmi_edge | (nmi_pend & ~nmi_clr);
    end
  end
  // T-state sequencing, opcode/interrupt fetch at T1 and NMI hijack of IRQ/BRK sequences
  always_ff @(posedge phi2) begin
    if (rst) begin
      tstate   <= 7'h01;
      IR       <= 8'h00;
      int_type <= 2'b11;
      B        <= 1'b0;
      take_int <= 1'b1;
      res_pend <= 1'b1;
      t_ovf    <= 1'b0;
    end else begin
      t_ovf <= RDY & tstate[6] & ~t_end;
      if (RDY) begin
        tstate   <= (t_end | tstate[6]) ? 7'h01 : tstate << 1;
        take_int <= t_end ? (nmi_pend | (~IRQ_n & ~I_flag)) : take_int & ~tstate[0];
        if (tstate[0]) begin
          IR       <= take_int ? 8'h00 : dataIn;
          B        <= ~take_int;
          int_type <= take_int ? win : 2'b00;
          res_pend <= res_pend & ~take_int;
        end else if (hijack)
          int_type <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_interrupt_timing_ctrl.sv
// tb_interrupt_timing_ctrl: randomized checks of sequencing, interrupts and vectors against a rule-level model
module tb_interrupt_timing_ctrl;
  logic       phi2 = 1'b0;
  logic       rst, RDY, NMI_n, IRQ_n, I_flag, t_end;
  logic [7:0] dataIn;
  logic [7:0] IR;
  logic [6:0] tstate;
  logic       SYNC, B, I_set, rw_suppress, O_ADL0, O_ADL1, O_ADL2, t_ovf;
  logic [1:0] int_type;
  int n_tests = 0;
  int n_fail = 0;
  int nmi_at = 0;
  logic [6:0] o_ts [1:7];
  logic [2:0] o_adl[1:7];
  logic [1:0] o_ty [1:7];
  logic [7:0] o_ir [1:7];
  logic       o_is [1:7];
  logic       o_rw [1:7];
  logic       o_np [1:7];
  logic       o_b  [1:7];

  interrupt_timing_ctrl dut (
    .phi2(phi2), .rst(rst), .RDY(RDY), .NMI_n(NMI_n), .IRQ_n(IRQ_n), .I_flag(I_flag),
    .t_end(t_end), .dataIn(dataIn), .IR(IR), .tstate(tstate), .SYNC(SYNC),
    .int_type(int_type), .B(B), .I_set(I_set), .rw_suppress(rw_suppress),
    .O_ADL0(O_ADL0), .O_ADL1(O_ADL1), .O_ADL2(O_ADL2), .t_ovf(t_ovf)
  );

  always #5 phi2 = ~phi2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  function automatic logic [15:0] vec_of(input logic [1:0] ty);
    return ty == 2'b11 ? 16'hFFFC : ty == 2'b10 ? 16'hFFFA : 16'hFFFE;
  endfunction

  function automatic logic [2:0] exp_adl(input logic [1:0] ty, input int t);
    logic [15:0] v;
    v = vec_of(ty) + ((t == 7) ? 16'd1 : 16'd0);
    return (t == 6 || t == 7) ? v[2:0] : 3'b111;
  endfunction

  function automatic logic [1:0] exp_kind(input logic nmi, input logic irq_n, input logic iflag);
    return nmi ? 2'b10 : (!irq_n && !iflag) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [7:0] rand_op();
    return 8'($urandom_range(1, 255));
  endfunction

  task automatic cyc();
    @(posedge phi2);
    #1;
  endtask

  task automatic run(input int len);
    for (int i = 1; i <= len; i++) begin
      o_ts[i]  = tstate;
      o_adl[i] = {O_ADL2, O_ADL1, O_ADL0};
      o_ty[i]  = int_type;
      o_ir[i]  = IR;
      o_is[i]  = I_set;
      o_rw[i]  = rw_suppress;
      o_np[i]  = dut.nmi_pend;
      o_b[i]   = B;
      NMI_n    = (i == nmi_at) ? 1'b0 : 1'b1;
      t_end    = (i == len);
      cyc();
    end
    t_end = 1'b0;
    NMI_n = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; RDY = 1'b1; NMI_n = 1'b1; IRQ_n = 1'b1; I_flag = 1'b1; t_end = 1'b0; dataIn = rand_op();
    cyc(); cyc();
    n_tests++; if (tstate !== 7'h01) begin n_fail++; $display("FAIL reset_tstate: got %h want 01", tstate); end
    n_tests++; if (IR !== 8'h00) begin n_fail++; $display("FAIL reset_ir: got %h want 00", IR); end
    n_tests++; if (int_type !== 2'b11) begin n_fail++; $display("FAIL reset_type: got %b want 11", int_type); end
    n_tests++; if ({B, I_set, t_ovf, rw_suppress} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {B, I_set, t_ovf, rw_suppress}); end
    n_tests++; if ({O_ADL2, O_ADL1, O_ADL0, SYNC} !== 4'b1111) begin n_fail++; $display("FAIL reset_adl_sync: got %b want 1111", {O_ADL2, O_ADL1, O_ADL0, SYNC}); end
    rst = 1'b0;
    run(7);
    for (int i = 1; i <= 7; i++) begin
      n_tests++; if (o_ts[i] !== 7'(1 << (i - 1))) begin n_fail++; $display("FAIL rseq_tstate T%0d: got %h want %h", i, o_ts[i], 7'(1 << (i - 1))); end
      n_tests++; if (o_rw[i] !== (i >= 3 && i <= 5)) begin n_fail++; $display("FAIL rseq_rw T%0d: got %b", i, o_rw[i]); end
      n_tests++; if (o_adl[i] !== exp_adl(2'b11, i)) begin n_fail++; $display("FAIL rseq_adl T%0d: got %b want %b", i, o_adl[i], exp_adl(2'b11, i)); end
      n_tests++; if (o_ty[i] !== 2'b11) begin n_fail++; $display("FAIL rseq_type T%0d: got %b want 11", i, o_ty[i]); end
    end
    dataIn = rand_op();
    run(2);
    n_tests++; if (o_ir[2] !== dataIn) begin n_fail++; $display("FAIL post_reset_ir: got %h want %h", o_ir[2], dataIn); end
    n_tests++; if ({o_ty[2], o_b[2]} !== 3'b001) begin n_fail++; $display("FAIL post_reset_type_b: got %b want 001", {o_ty[2], o_b[2]}); end
  endtask

  task automatic test_irq();
    logic irq_n, iflag;
    logic [1:0] k;
    logic [7:0] op;
    for (int n = 0; n < 8; n++) begin
      irq_n = (n < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      iflag = (n == 0) ? 1'b0 : (n == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      k = exp_kind(1'b0, irq_n, iflag);
      op = rand_op();
      dataIn = op; IRQ_n = irq_n; I_flag = iflag;
      run(2);
      n_tests++; if (o_ir[2] !== op) begin n_fail++; $display("FAIL irq_pre_ir: got %h want %h", o_ir[2], op); end
      IRQ_n = 1'b1;
      op = rand_op();
      dataIn = op;
      if (k != 2'b00) begin
        run(7);
        n_tests++; if ({o_ir[2], o_ty[2], o_b[2]} !== {8'h00, k, 1'b0}) begin n_fail++; $display("FAIL irq_entry: got ir=%h type=%b b=%b want ir=00 type=%b b=0", o_ir[2], o_ty[2], o_b[2], k); end
        for (int i = 1; i <= 7; i++) begin
          n_tests++; if (o_adl[i] !== exp_adl(k, i)) begin n_fail++; $display("FAIL irq_adl T%0d: got %b want %b", i, o_adl[i], exp_adl(k, i)); end
          n_tests++; if (o_is[i] !== (i == 6)) begin n_fail++; $display("FAIL irq_iset T%0d: got %b", i, o_is[i]); end
        end
      end else begin
        run(2);
        n_tests++; if ({o_ir[2], o_ty[2], o_b[2]} !== {op, 2'b00, 1'b1}) begin n_fail++; $display("FAIL irq_masked: got ir=%h type=%b b=%b want ir=%h type=00 b=1", o_ir[2], o_ty[2], o_b[2], op); end
      end
    end
    I_flag = 1'b1;
  endtask

  task automatic test_nmi();
    logic [1:0] k;
    logic [7:0] op;
    RDY = 1'b0; NMI_n = 1'b0;
    cyc();
    NMI_n = 1'b1;
    n_tests++; if (dut.nmi_pend !== 1'b1) begin n_fail++; $display("FAIL nmi_pend_set: got %b want 1", dut.nmi_pend); end
    cyc();
    n_tests++; if (tstate !== 7'h01) begin n_fail++; $display("FAIL nmi_freeze_tstate: got %h want 01", tstate); end
    RDY = 1'b1;
    op = rand_op();
    dataIn = op;
    run(3);
    n_tests++; if (o_ir[2] !== op) begin n_fail++; $display("FAIL nmi_pre_ir: got %h want %h", o_ir[2], op); end
    k = exp_kind(1'b1, IRQ_n, I_flag);
    dataIn = rand_op();
    run(7);
    n_tests++; if ({o_ir[2], o_ty[2], o_b[2]} !== {8'h00, k, 1'b0}) begin n_fail++; $display("FAIL nmi_entry: got ir=%h type=%b b=%b want ir=00 type=%b b=0", o_ir[2], o_ty[2], o_b[2], k); end
    n_tests++; if (o_adl[6] !== exp_adl(k, 6)) begin n_fail++; $display("FAIL nmi_adl_t6: got %b want %b", o_adl[6], exp_adl(k, 6)); end
    n_tests++; if (o_adl[7] !== exp_adl(k, 7)) begin n_fail++; $display("FAIL nmi_adl_t7: got %b want %b", o_adl[7], exp_adl(k, 7)); end
    n_tests++; if ({o_np[6], o_np[7]} !== 2'b10) begin n_fail++; $display("FAIL nmi_pend_clear: got %b want 10", {o_np[6], o_np[7]}); end
    n_tests++; if (o_is[6] !== 1'b1) begin n_fail++; $display("FAIL nmi_iset: got %b want 1", o_is[6]); end
  endtask

  task automatic test_brk_hijack();
    logic [1:0] k;
    dataIn = 8'h00;
    nmi_at = 4;
    run(7);
    nmi_at = 0;
    k = exp_kind(1'b1, 1'b1, 1'b1);
    n_tests++; if ({o_ir[2], o_ty[2], o_b[2]} !== {8'h00, 2'b00, 1'b1}) begin n_fail++; $display("FAIL brk_entry: got ir=%h type=%b b=%b want ir=00 type=00 b=1", o_ir[2], o_ty[2], o_b[2]); end
    n_tests++; if (o_ty[6] !== k) begin n_fail++; $display("FAIL brk_hijack_type: got %b want %b", o_ty[6], k); end
    n_tests++; if ({o_adl[6], o_adl[7]} !== {exp_adl(k, 6), exp_adl(k, 7)}) begin n_fail++; $display("FAIL brk_hijack_vec: got %b want %b", {o_adl[6], o_adl[7]}, {exp_adl(k, 6), exp_adl(k, 7)}); end
    n_tests++; if (o_b[7] !== 1'b1) begin n_fail++; $display("FAIL brk_b: got %b want 1", o_b[7]); end
    n_tests++; if (o_is[6] !== 1'b1) begin n_fail++; $display("FAIL brk_iset: got %b want 1", o_is[6]); end
  endtask

  task automatic test_timeout();
    dataIn = rand_op();
    t_end = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      n_tests++; if (t_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early T%0d: got %b want 0", i, t_ovf); end
      cyc();
    end
    n_tests++; if ({tstate, t_ovf} !== {7'h01, 1'b1}) begin n_fail++; $display("FAIL ovf_wrap: got ts=%h ovf=%b want ts=01 ovf=1", tstate, t_ovf); end
    cyc();
    n_tests++; if ({tstate, t_ovf} !== {7'h02, 1'b0}) begin n_fail++; $display("FAIL ovf_pulse_end: got ts=%h ovf=%b want ts=02 ovf=0", tstate, t_ovf); end
    t_end = 1'b1;
    cyc();
    t_end = 1'b0;
  endtask

  task automatic test_rdy_rst();
    logic [7:0] op;
    op = rand_op();
    dataIn = op;
    cyc(); cyc();
    n_tests++; if ({tstate, IR} !== {7'h04, op}) begin n_fail++; $display("FAIL rdy_t3: got ts=%h ir=%h want ts=04 ir=%h", tstate, IR, op); end
    RDY = 1'b0;
    dataIn = ~op;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests++; if ({tstate, IR} !== {7'h04, op}) begin n_fail++; $display("FAIL rdy_hold %0d: got ts=%h ir=%h want ts=04 ir=%h", i, tstate, IR, op); end
    end
    RDY = 1'b1;
    cyc();
    n_tests++; if (tstate !== 7'h08) begin n_fail++; $display("FAIL rdy_resume: got %h want 08", tstate); end
    rst = 1'b1; RDY = 1'b0;
    cyc();
    n_tests++; if ({tstate, int_type, IR} !== {7'h01, 2'b11, 8'h00}) begin n_fail++; $display("FAIL mid_rst: got ts=%h type=%b ir=%h want ts=01 type=11 ir=00", tstate, int_type, IR); end
    rst = 1'b0; RDY = 1'b1;
    run(7);
    n_tests++; if ({o_ty[2], o_adl[6]} !== {2'b11, exp_adl(2'b11, 6)}) begin n_fail++; $display("FAIL mid_rst_seq: got %b want %b", {o_ty[2], o_adl[6]}, {2'b11, exp_adl(2'b11, 6)}); end
  endtask

  initial begin
    test_reset();
    test_irq();
    test_nmi();
    test_brk_hijack();
    test_timeout();
    test_rdy_rst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/interrupt_timing_ctrl.md
INTERRUPT_TIMING_CTRL -- requirements
Module: interrupt_timing_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have the port `phi2`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port `RDY`, input, 1 bit: 1 = advance, 0 = freeze.
REQ-005 The block SHALL have the port `NMI_n`, input, 1 bit: non-maskable interrupt, falling-edge sensitive.
REQ-006 The block SHALL have the port `IRQ_n`, input, 1 bit: maskable interrupt, level sensitive.
REQ-007 The block SHALL have the port `I_flag`, input, 1 bit: status I bit from the status register.
REQ-008 The block SHALL have the port `t_end`, input, 1 bit: from decode; marks the final cycle of the current instruction.
REQ-009 The block SHALL have the port `dataIn`, input, 8 bits: opcode byte from the input data latch.
REQ-010 The block SHALL have the port `IR`, output, 8 bits: instruction register.
REQ-011 The block SHALL have the port `tstate`, output, 7 bits: one-hot T1..T7; bit0 = T1, the opcode fetch.
REQ-012 The block SHALL have the port `SYNC`, output, 1 bit: high in T1.
REQ-013 The block SHALL have the port `int_type`, output, 2 bits: 00 none/BRK, 01 IRQ, 10 NMI, 11 RESET.
REQ-014 The block SHALL have the port `B`, output, 1 bit: B bit to the status register.
REQ-015 The block SHALL have the port `I_set`, output, 1 bit: one-cycle pulse to set I.
REQ-016 The block SHALL have the port `rw_suppress`, output, 1 bit: 1 converts stack writes to reads.
REQ-017 The block SHALL have the ports `O_ADL0`, `O_ADL1`, `O_ADL2`, outputs, 1 bit each: active-low vector-force enables for ADL bits 0–2; idle value 1.
REQ-018 The block SHALL have the port `t_ovf`, output, 1 bit: one-cycle pulse on T7 timeout.

Function
REQ-019 When RDY=0, tstate, IR, int_type, B, the pending flags and the sequence state SHALL hold; the NMI edge detector SHALL keep sampling.
REQ-020 Advance, with RDY=1: if t_end=1, next tstate = T1; otherwise tstate shifts left one position.
REQ-021 If tstate=T7 and t_end=0, next tstate SHALL be T1 and t_ovf SHALL pulse for 1 cycle.
REQ-022 SYNC SHALL equal tstate[0] combinationally.
REQ-023 At the T1 edge with RDY=1: if `take_int`=1, IR <= 8'h00, B <= 0 and int_type <= the winning source; otherwise IR <= dataIn, int_type <= 00 and B <= 1 (0 only during an interrupt sequence).
REQ-024 The NMI edge detector SHALL set nmi_pend when the registered NMI_n goes 1 -> 0.
REQ-025 nmi_pend SHALL clear at T6 of a sequence whose int_type is NMI.
REQ-026 A new NMI edge in the same cycle as the clear SHALL leave nmi_pend set (set wins).
REQ-027 `take_int` SHALL be latched in the cycle where t_end=1 and RDY=1, as nmi_pend OR (IRQ_n=0 AND I_flag=0); IRQ is not latched otherwise.
REQ-028 Interrupt priority SHALL be RESET > NMI > IRQ.
REQ-029 NMI hijack: if nmi_pend becomes set during T2–T5 of an IRQ or BRK sequence (IR=00), int_type SHALL switch to 10 before T6.
REQ-030 Vector force, low byte (T6 of an IR=00 sequence): O_ADL0=0; O_ADL1=0 only for RESET; O_ADL2=0 only for NMI.
REQ-031 Vector force, high byte (T7 of an IR=00 sequence): O_ADL0=1; O_ADL1 and O_ADL2 as in REQ-030.
REQ-032 The resulting vectors SHALL be FFFE/FFFF for IRQ/BRK, FFFA/FFFB for NMI and FFFC/FFFD for RESET.
REQ-033 Outside the vector cycles, all O_ADL outputs SHALL be 1.
REQ-034 I_set SHALL pulse at T6 of every IR=00 sequence, including BRK.
REQ-035 rw_suppress SHALL be 1 during T3–T5 of a RESET sequence and 0 otherwise.
REQ-036 Outputs SHALL be combinational from registered state only.

Reset
REQ-037 While rst=1: tstate=T1, IR=8'h00, int_type=11, B=0, nmi_pend=0, take_int=1, I_set=0, t_ovf=0, O_ADL*=1 and rw_suppress=0; the NMI edge register SHALL load 1.
REQ-038 After rst falls, the first T1 edge SHALL start the RESET sequence (IR=00); the sequence runs T1..T7 and fetches FFFC/FFFD.
REQ-039 rst=1 mid-sequence SHALL abort the sequence immediately, and rst SHALL override RDY=0.
REQ-040 After the RESET sequence completes, int_type SHALL return to 00 at the next T1.

Verification
REQ-041 The bench SHALL release rst with RDY=1 and t_end at T7, and check that tstate walks 0x01..0x40, rw_suppress=1 in T3–T5, the T6 O_ADL{2,1,0}=1,0,0 and the T7 O_ADL{2,1,0}=1,0,1.
REQ-042 The bench SHALL apply IRQ_n=0 with I_flag=0 at the t_end of a 2-cycle instruction, and check that the next IR=00, int_type=01, B=0, T6 O_ADL{2,1,0}=1,1,0 and I_set pulses at T6; a repeat with I_flag=1 SHALL give IR=dataIn and no sequence.
REQ-043 The bench SHALL pulse NMI_n low for 1 cycle during RDY=0, and check that nmi_pend sets, a sequence is taken at the next t_end, int_type=10, T6 O_ADL{2,1,0}=0,1,0, and nmi_pend clears at T6.
REQ-044 The bench SHALL apply BRK (dataIn=00) with an NMI edge at T4, and check that int_type switches to 10, the vector is FFFA and B=1 is retained.
REQ-045 The bench SHALL hold t_end=0 through T7, and check that the next state is T1 and t_ovf pulses exactly 1 cycle.
REQ-046 The bench SHALL hold RDY=0 for 3 cycles mid-T3, and check that tstate and IR are unchanged; the bench SHALL also assert rst at T4, and check T1 with int_type=11 on the next edge.
